// File: rtl/cpu_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl_if
//   Bundles the signals between the run controller and the surrounding
//   system (user controls, datapath status, datapath control).
//
//   Parameter
//     CNT_W      width of instr_cnt; must match the controller's CNT_W.
//
//   Signals
//     start      level; 1 = execution permitted, 0 = return to idle
//     enable     level; 1 = continuous run, 0 = single-step mode
//     button     raw, asynchronous, bouncing step push-button
//     halt       datapath has retired a halt instruction
//     pc         current datapath PC (breakpoint compare)
//     bp_addr    breakpoint address
//     bp_valid   breakpoint armed by the user
//     cpu_en     clock enable for the datapath pipeline registers
//     cpu_clear  one-cycle synchronous clear pulse to the datapath
//     state      current controller state encoding
//     instr_cnt  number of cycles in which cpu_en was 1
//     bp_hit     sticky breakpoint-hit flag
//
//   There is no valid/ready handshake on this bundle: every input is a
//   level sampled on each rising clock edge, and every output is a Moore
//   output that is stable for the whole cycle.
//
//   Modports
//     master  the system side: drives controls, observes controller outputs
//     slave   the run controller itself
// ---------------------------------------------------------------------------
interface cpu_run_ctrl_if #(
  parameter int CNT_W = 16
) ();

  logic             start;
  logic             enable;
  logic             button;
  logic             halt;
  logic [7:0]       pc;
  logic [7:0]       bp_addr;
  logic             bp_valid;
  logic             cpu_en;
  logic             cpu_clear;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_cnt;
  logic             bp_hit;

  modport master (
    output start,
    output enable,
    output button,
    output halt,
    output pc,
    output bp_addr,
    output bp_valid,
    input  cpu_en,
    input  cpu_clear,
    input  state,
    input  instr_cnt,
    input  bp_hit
  );

  modport slave (
    input  start,
    input  enable,
    input  button,
    input  halt,
    input  pc,
    input  bp_addr,
    input  bp_valid,
    output cpu_en,
    output cpu_clear,
    output state,
    output instr_cnt,
    output bp_hit
  );

endinterface

// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
//   Run/step controller for a small CPU datapath. It gates the datapath with
//   a clock enable (cpu_en), issues a one-cycle clear when execution starts,
//   supports continuous run and single-step (debounced push-button) modes,
//   stops on a retired halt instruction, and counts executed cycles.
//
//   Optional feature (compile-time macro RUN_CTRL_BREAK_EN):
//     defined   - a PC breakpoint drops RUN into STEP and sets sticky bp_hit.
//                 The breakpoint disarms once taken and re-arms on any cycle
//                 where pc != bp_addr, so resuming from the breakpoint PC
//                 does not immediately re-trigger.
//     undefined - pc/bp_addr/bp_valid are ignored and bp_hit is tied to 0.
//
//   Parameters
//     DB_CYCLES  consecutive stable cycles needed to accept a new button level
//     CNT_W      width of instr_cnt
//
//   Ports
//     clk        single clock, rising edge
//     reset_cpu  asynchronous active-low reset
//     bus        cpu_run_ctrl_if.slave (see the interface file for signals)
//
//   State encoding (visible on bus.state):
//     IDLE=0 CLEAR=1 RUN=2 STEP=3 PULSE=4 HALT=5
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 16
) (
  input  logic           clk,
  input  logic           reset_cpu,
  cpu_run_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_STEP  = 3'd3,
    S_PULSE = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  // The debounce counter only needs to reach DB_CYCLES-1: the flip happens
  // on the DB_CYCLES-th consecutive differing sample.
  localparam int              DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  state_e           state_q;
  state_e           state_d;

  logic             sync1_q;
  logic             sync2_q;
  logic [DB_W-1:0]  db_cnt_q;
  logic             btn_db_q;
  logic             btn_db_d1_q;
  logic             btn_rise;

  logic [CNT_W-1:0] cnt_q;
  logic             enter_clear;
  logic             run_like;
  logic             bp_take;
  logic             bp_hit_w;

  // -------------------------------------------------------------------------
  // Button path: 2-flop synchronizer, then a debouncer that accepts a new
  // level only after it has been seen for DB_CYCLES consecutive cycles.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_cpu) begin
    if (!reset_cpu) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      db_cnt_q    <= '0;
      btn_db_q    <= 1'b0;
      btn_db_d1_q <= 1'b0;
    end else begin
      sync1_q     <= bus.button;
      sync2_q     <= sync1_q;
      btn_db_d1_q <= btn_db_q;
      if (sync2_q != btn_db_q) begin
        if (db_cnt_q == DB_LAST) begin
          btn_db_q <= sync2_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DB_W'(1);
        end
      end else begin
        // Any reversion to the accepted level restarts the qualification.
        db_cnt_q <= '0;
      end
    end
  end

  // Single-cycle pulse on each accepted press; a held button yields one.
  assign btn_rise = btn_db_q & ~btn_db_d1_q;

  // -------------------------------------------------------------------------
  // Optional breakpoint logic
  // -------------------------------------------------------------------------
`ifdef RUN_CTRL_BREAK_EN
  logic armed_q;
  logic bp_hit_q;
  logic pc_at_bp;

  assign pc_at_bp = (bus.pc == bus.bp_addr);

  // A breakpoint is only "taken" when it actually steers RUN into STEP,
  // i.e. neither start=0 nor halt=1 has precedence this cycle.
  assign bp_take = (state_q == S_RUN) && bus.start && !bus.halt &&
                   bus.bp_valid && pc_at_bp && armed_q;

  always_ff @(posedge clk or negedge reset_cpu) begin
    if (!reset_cpu) begin
      armed_q  <= 1'b1;
      bp_hit_q <= 1'b0;
    end else begin
      if (enter_clear) begin
        bp_hit_q <= 1'b0;
      end else if (bp_take) begin
        bp_hit_q <= 1'b1;
      end
      if (!pc_at_bp) begin
        armed_q <= 1'b1;
      end else if (bp_take) begin
        armed_q <= 1'b0;
      end
    end
  end

  assign bp_hit_w = bp_hit_q;
`else
  logic unused_bp;

  assign bp_take   = 1'b0;
  assign bp_hit_w  = 1'b0;
  assign unused_bp = ^{bus.pc, bus.bp_addr, bus.bp_valid};
`endif

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_cpu) begin
    if (!reset_cpu) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && !bus.start) begin
      // Dropping start wins over every other transition.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) state_d = S_CLEAR;
        end
        S_CLEAR: begin
          state_d = bus.enable ? S_RUN : S_STEP;
        end
        S_RUN: begin
          if (bus.halt)         state_d = S_HALT;
          else if (bp_take)     state_d = S_STEP;
          else if (!bus.enable) state_d = S_STEP;
        end
        S_STEP: begin
          // btn_rise is only consumed here; elsewhere it is simply dropped.
          if (bus.enable)    state_d = S_RUN;
          else if (btn_rise) state_d = S_PULSE;
        end
        S_PULSE: begin
          state_d = bus.halt ? S_HALT : S_STEP;
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // CLEAR is only ever entered from IDLE; clearing on entry makes the
  // counter and sticky flag read zero while the clear pulse is visible.
  assign enter_clear = (state_q == S_IDLE) && bus.start;

  // Gating with reset_cpu makes cpu_en drop the moment reset is asserted,
  // independent of the state register's own reset timing.
  assign run_like = reset_cpu && ((state_q == S_RUN) || (state_q == S_PULSE));

  // -------------------------------------------------------------------------
  // Executed-cycle counter (wraps naturally at 2^CNT_W)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_cpu) begin
    if (!reset_cpu) begin
      cnt_q <= '0;
    end else if (enter_clear) begin
      cnt_q <= '0;
    end else if (run_like) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Moore outputs
  // -------------------------------------------------------------------------
  assign bus.cpu_en    = run_like;
  assign bus.cpu_clear = reset_cpu && (state_q == S_CLEAR);
  assign bus.state     = state_q;
  assign bus.instr_cnt = cnt_q;
  assign bus.bp_hit    = bp_hit_w;

endmodule
